collatz_range: RTL
==================

# collatz_range

Responder behind the lab top level's go/start/done/count interface. A go pulse launches a batch: Collatz sequence lengths are computed for RAM_WORDS consecutive starting values beginning at start, and each length is written into an internal RAM. Afterwards, done stays high and the top level reads any result back by word address. The block sits between the debounced UI logic and the 7-segment count display.

## Interface
- RAM_WORDS, 256, number of consecutive start values per batch and the RAM depth
- RAM_ADDR_BITS, 8, RAM address width; must satisfy 2**RAM_ADDR_BITS >= RAM_WORDS
- clk  input  1  system clock; all logic is on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- go  input  1  single-cycle start request
- start  input  32  first start value of the batch
- done  output  1  high when a batch is complete and results are valid
- n  input  12  read address; only n[RAM_ADDR_BITS-1:0] is used, upper bits are ignored
- count  output  16  RAM contents at address n (registered)

## Operation
- Sequence length is the number of terms including start and the final 1. Examples: 1→1, 2→2, 3→8, 27→112 (0x70).
- Start value 0 is written as 0 with no iteration.
- Step rule: even v → v>>1; odd v → 3v+1, computed at 34 bits.
  - If 3v+1 ≥ 2^32, the word is written as 16'hFFFF and the value is terminated.
  - The count saturates at 16'hFFFF; when the count reaches 16'hFFFF, the value is terminated.
- Word i uses start+i mod 2^32, for i = 0..RAM_WORDS-1.
- FSM states:
  - IDLE → START when go=1.
  - START: load the engine with start+i, pulse engine go → RUN.
  - RUN: wait for the engine's done → WRITE.
  - WRITE: write RAM[i], then either i++ and → START, or → DONE if i == RAM_WORDS-1.
  - DONE → START when go=1, with i cleared and start re-latched.
- start is latched only on an accepted go; changes to start mid-batch are ignored.
- go is ignored in START, RUN and WRITE.
- count is registered RAM[n[RAM_ADDR_BITS-1:0]] and is valid in any state. Words not yet written in the current batch hold stale contents.

## Timing
- Reset values: done=0, count=0, FSM=IDLE, i=0. RAM contents are not reset.
- The go accepted at edge k clears done at edge k+1, if it was set.
- done rises on the edge following the last WRITE and holds until the next accepted go or reset.
- Engine latency: the engine's done pulses L cycles after its go, where L = the written count (1 for start 1, 1 for start 0). Total per word is L+2 cycles.
- Read latency: count reflects n one cycle after n changes.
- When rst_n=0 on any edge, including mid-batch, the FSM returns to IDLE, done=0, the engine is idled, and the partial results are left in RAM.
- A write and a read at the same address in the same cycle return the old data.

## Configuration
- COLLATZ_FAST_EN defined:
  - An odd step computes (3v+1)>>1 in one cycle and adds 2 to the count, saturating at 16'hFFFF.
  - RAM results are bit-identical to the non-fast mode. Only cycle counts shrink.
  - For start 3, the engine latency drops from 8 to 6 cycles.
- Undefined: one step per cycle as described above.

## Structure
- Package collatz_pkg holds:
  - VALUE_W=32, COUNT_W=16, COUNT_MAX=16'hFFFF
  - the FSM state enum (IDLE, START, RUN, WRITE, DONE)
- Sub-module collatz_engine (clk, rst_n, go, value_in, done, count_out) performs the single-value iteration, including the overflow and saturation rules.
- The RAM is an inferred synchronous-read array inside collatz_range.

## Test plan
- Reset test: hold rst_n=0 for 2 cycles → done=0, count=0. Then hold go=0 for 100 cycles → done stays 0.
- Basic batch: go with start=1, wait for done.
  - Read n=0,1,2,26 → 1, 2, 8, 0x70.
  - Read n=255 → the length for start 256, which is 9.
- Edge values: start=0 → RAM[0]=0, RAM[1]=1.
- Overflow: start=32'hAAAA_AAAB → RAM[0]=16'hFFFF.
- Busy and reset interactions:
  - go with start=5 during RUN of a start=1 batch → ignored; results match start=1.
  - rst_n=0 mid-batch → done=0; a new go with start=10 completes with RAM[0]=7.
- Fast mode: with and without COLLATZ_FAST_EN, the same start=1000 batch gives identical RAM contents. The fast build's done asserts strictly earlier.

Source files
------------

// File: rtl/collatz_pkg.sv
// Shared types and constants for the collatz_range block.
// Optional build macro: COLLATZ_FAST_EN (merged odd step in the engine).
package collatz_pkg;

    localparam int              VALUE_W   = 32;
    localparam int              COUNT_W   = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        WRITE,
        DONE
    } state_e;

    // Saturating count increment; never wraps past COUNT_MAX.
    function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] c,
                                                   input logic [COUNT_W-1:0] inc);
        logic [COUNT_W:0] s;
        s = {1'b0, c} + {1'b0, inc};
        return s[COUNT_W] ? COUNT_MAX : s[COUNT_W-1:0];
    endfunction

endpackage

// File: rtl/collatz_engine.sv
// Single-value Collatz iterator: one step per cycle, done is combinational
// from the running state so a value of 1 (or 0) finishes in the cycle after go.
// With COLLATZ_FAST_EN an odd step also performs the following halving.
module collatz_engine
    import collatz_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [VALUE_W-1:0] value_in,
    output logic               done,
    output logic [COUNT_W-1:0] count_out
);

    logic               busy_q, busy_d;
    logic [VALUE_W-1:0] v_q, v_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic [VALUE_W+1:0] tri_v;   // 3v+1 with two guard bits for overflow detection
    logic               finish;

    assign tri_v     = {2'b00, v_q} + {1'b0, v_q, 1'b0} + 34'd1;
    // Overflow forces cnt to COUNT_MAX, so it terminates through the same test.
    assign finish    = busy_q && ((v_q <= 32'd1) || (cnt_q == COUNT_MAX));
    assign done      = finish;
    assign count_out = (v_q == '0) ? '0 : cnt_q;

`ifdef COLLATZ_FAST_EN
    logic unused_lsb;
    assign unused_lsb = tri_v[0];
`endif

    // Next-state: load on go, otherwise step until 1, overflow or saturation.
    always_comb begin
        busy_d = busy_q;
        v_d    = v_q;
        cnt_d  = cnt_q;
        if (!busy_q) begin
            if (go) begin
                busy_d = 1'b1;
                v_d    = value_in;
                cnt_d  = 16'd1;
            end
        end else if (finish) begin
            busy_d = 1'b0;
        end else if (!v_q[0]) begin
            v_d   = v_q >> 1;
            cnt_d = sat_add(cnt_q, 16'd1);
        end else if (tri_v[VALUE_W+1:VALUE_W] != 2'b00) begin
            cnt_d = COUNT_MAX;
        end else begin
`ifdef COLLATZ_FAST_EN
            v_d   = tri_v[VALUE_W:1];
            cnt_d = sat_add(cnt_q, 16'd2);
`else
            v_d   = tri_v[VALUE_W-1:0];
            cnt_d = sat_add(cnt_q, 16'd1);
`endif
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            v_q    <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            v_q    <= v_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/collatz_range.sv
// Batch controller: runs the engine over RAM_WORDS consecutive start values,
// stores each sequence length in an internal RAM, and serves registered reads.
// Optional build macro: COLLATZ_FAST_EN (passed through to the engine).
module collatz_range
    import collatz_pkg::*;
#(
    parameter int RAM_WORDS     = 256,
    parameter int RAM_ADDR_BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               go,
    input  logic [VALUE_W-1:0] start,
    output logic               done,
    input  logic [11:0]        n,
    output logic [COUNT_W-1:0] count
);

    localparam logic [RAM_ADDR_BITS-1:0] LAST = RAM_ADDR_BITS'(RAM_WORDS - 1);

    state_e                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] i_q, i_d;
    logic [VALUE_W-1:0]       start_q, start_d;
    logic [COUNT_W-1:0]       res_q, res_d;
    logic                     done_q, done_d;
    logic [COUNT_W-1:0]       count_q, count_d;

    logic                     eng_go, eng_done, we;
    logic [COUNT_W-1:0]       eng_count;
    logic [COUNT_W-1:0]       mem [RAM_WORDS];

    // Upper read-address bits are intentionally ignored.
    logic unused_n;
    assign unused_n = ^n;

    collatz_engine u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (eng_go),
        .value_in  (start_q + VALUE_W'(i_q)),
        .done      (eng_done),
        .count_out (eng_count)
    );

    // Batch FSM; done is cleared one edge after the accepting go (in START).
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        start_d = start_q;
        res_d   = res_q;
        done_d  = done_q;
        eng_go  = 1'b0;
        we      = 1'b0;
        count_d = mem[n[RAM_ADDR_BITS-1:0]];
        case (state_q)
            IDLE, DONE: begin
                if (go) begin
                    state_d = START;
                    i_d     = '0;
                    start_d = start;
                end
            end
            START: begin
                eng_go  = 1'b1;
                done_d  = 1'b0;
                state_d = RUN;
            end
            RUN: begin
                if (eng_done) begin
                    res_d   = eng_count;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                we = 1'b1;
                if (i_q == LAST) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    i_d     = i_q + RAM_ADDR_BITS'(1);
                    state_d = START;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and read registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            start_q <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            start_q <= start_d;
            res_q   <= res_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    // Result RAM: not reset, so partial batches survive a reset.
    always_ff @(posedge clk) begin
        if (we) mem[i_q] <= res_q;
    end

    assign done  = done_q;
    assign count = count_q;

endmodule
